// File: rtl/vram_arbiter_if.sv
// Bundle of every requester and RAM-side signal of the video RAM arbiter.
//   master : the environment (VGA fetch, CPU bus, DMA engine and the RAM macro)
//   slave  : the arbiter itself
// Requester ports: *_req/*_we/*_addr/*_wdata toward the arbiter, *_ack/*_rdata back.
// RAM ports: mem_en/mem_we/mem_addr/mem_wdata toward the RAM, mem_rdata back.
interface vram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  vid_ack, vid_rdata, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output vid_ack, vid_rdata, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous video RAM (1-cycle read latency) between
// video fetch, CPU and DMA. Video has strict priority; CPU and DMA alternate
// round-robin. One access may be issued per cycle, at most one outstanding per
// requester; each access is acked exactly two cycles after its grant.
// Ports: clk, rst_n (async, active low), bus (vram_arbiter_if.slave) carrying
// the three requester handshakes and the RAM strobe/address/data signals.
module vram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  // bit 0 video, bit 1 cpu, bit 2 dma
  function automatic logic [2:0] owner_mask(input owner_t o);
    case (o)
      OWN_VID: owner_mask = 3'b001;
      OWN_CPU: owner_mask = 3'b010;
      OWN_DMA: owner_mask = 3'b100;
      default: owner_mask = 3'b000;
    endcase
  endfunction

  logic [2:0]    busy_r;       // outstanding access per requester
  logic          rr_dma_r;     // 1 = DMA wins the next CPU/DMA tie
  owner_t        own1_r;       // owner of the access presented to the RAM
  owner_t        own2_r;       // owner of the access whose data is on mem_rdata
  logic          we2_r;

  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  logic          vid_ack_r, cpu_ack_r, dma_ack_r;
  logic [DW-1:0] vid_rdata_r, cpu_rdata_r, dma_rdata_r;

  logic [2:0]    elig_s;
  owner_t        grant_s;
  logic          rr_dma_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Arbitration: video first, then CPU/DMA by round-robin pointer
  always_comb begin
    elig_s   = {bus.dma_req & ~busy_r[2], bus.cpu_req & ~busy_r[1], bus.vid_req & ~busy_r[0]};
    grant_s  = OWN_NONE;
    rr_dma_s = rr_dma_r;
    if (elig_s[0]) begin
      grant_s = OWN_VID;
    end else if (elig_s[1] && (!elig_s[2] || !rr_dma_r)) begin
      grant_s  = OWN_CPU;
      rr_dma_s = 1'b1;
    end else if (elig_s[2]) begin
      grant_s  = OWN_DMA;
      rr_dma_s = 1'b0;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Request mux: the winner's access fields; video never writes and keeps wdata
  always_comb begin
    sel_we_s    = mem_we_r;
    sel_addr_s  = mem_addr_r;
    sel_wdata_s = mem_wdata_r;
    case (grant_s)
      OWN_VID: begin
        sel_we_s   = 1'b0;
        sel_addr_s = bus.vid_addr;
      end
      OWN_CPU: begin
        sel_we_s    = bus.cpu_we;
        sel_addr_s  = bus.cpu_addr;
        sel_wdata_s = bus.cpu_wdata;
      end
      OWN_DMA: begin
        sel_we_s    = bus.dma_we;
        sel_addr_s  = bus.dma_addr;
        sel_wdata_s = bus.dma_wdata;
      end
      default: begin
        sel_we_s    = mem_we_r;
        sel_addr_s  = mem_addr_r;
        sel_wdata_s = mem_wdata_r;
      end
    endcase
  end

  // Issue stage and owner pipeline tracking the RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      own1_r      <= OWN_NONE;
      own2_r      <= OWN_NONE;
      we2_r       <= 1'b0;
    end else begin
      mem_en_r <= (grant_s != OWN_NONE);
      if (grant_s != OWN_NONE) begin
        mem_we_r    <= sel_we_s;
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
      end else begin
        mem_we_r    <= mem_we_r;
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      own1_r <= grant_s;
      own2_r <= own1_r;
      we2_r  <= mem_we_r;
    end
  end

  // Completion stage: ack pulse, read data capture, outstanding and RR bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_ack_r   <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dma_ack_r   <= 1'b0;
      vid_rdata_r <= '0;
      cpu_rdata_r <= '0;
      dma_rdata_r <= '0;
      busy_r      <= 3'b000;
      rr_dma_r    <= 1'b0;
    end else begin
      vid_ack_r <= (own2_r == OWN_VID);
      cpu_ack_r <= (own2_r == OWN_CPU);
      dma_ack_r <= (own2_r == OWN_DMA);
      if ((own2_r == OWN_VID) && !we2_r) vid_rdata_r <= bus.mem_rdata;
      else                               vid_rdata_r <= vid_rdata_r;
      if ((own2_r == OWN_CPU) && !we2_r) cpu_rdata_r <= bus.mem_rdata;
      else                               cpu_rdata_r <= cpu_rdata_r;
      if ((own2_r == OWN_DMA) && !we2_r) dma_rdata_r <= bus.mem_rdata;
      else                               dma_rdata_r <= dma_rdata_r;
      // Eligibility above used the pre-clear flags, so a requester is never
      // regranted on the edge of its own ack.
      busy_r   <= (busy_r & ~owner_mask(own2_r)) | owner_mask(grant_s);
      rr_dma_r <= rr_dma_s;
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.vid_ack   = vid_ack_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.vid_rdata = vid_rdata_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dma_rdata = dma_rdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model (priority rules,
// grant+2 ack timing, RAM contents in grant order).
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vram_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Background contents of never-written locations; 0x0123 holds 0x5A.
  function automatic logic [7:0] seed(input logic [12:0] a);
    if (a == 13'h0123) seed = 8'h5A;
    else               seed = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
  endfunction

  // ---------------- RAM model (1-cycle registered read) ----------------
  logic [7:0] tb_ram [0:8191];
  bit         tb_wr  [0:8191];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        tb_ram[bus.mem_addr] <= bus.mem_wdata;
        tb_wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= tb_wr[bus.mem_addr] ? tb_ram[bus.mem_addr] : seed(bus.mem_addr);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:8191];
  bit          ref_wr  [0:8191];
  bit          m_pend  [3] = '{0, 0, 0};
  int          m_due   [3] = '{0, 0, 0};
  bit          m_pwe   [3] = '{0, 0, 0};
  logic [7:0]  m_pdata [3] = '{8'd0, 8'd0, 8'd0};
  bit          e_ack   [3] = '{0, 0, 0};
  logic [7:0]  e_rdata [3] = '{8'd0, 8'd0, 8'd0};
  bit          e_en = 1'b0, e_we = 1'b0;
  logic [12:0] e_addr = 13'd0;
  logic [7:0]  e_wd = 8'd0;
  bit          m_fav_dma = 1'b0;
  int          m_cyc = 0;
  bit          lw_valid = 1'b0, lw_oldv = 1'b0;
  logic [12:0] lw_addr = 13'd0;
  logic [7:0]  lw_old = 8'd0;

  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    ref_rd = ref_wr[a] ? ref_mem[a] : seed(a);
  endfunction

  task automatic model_step();
    bit          el [3];
    int          win;
    bit          we;
    logic [12:0] a;
    logic [7:0]  wd;
    lw_valid = 1'b0;  // the previous grant has now reached the RAM
    el[0] = bus.vid_req && !m_pend[0];
    el[1] = bus.cpu_req && !m_pend[1];
    el[2] = bus.dma_req && !m_pend[2];
    win = -1;
    if (el[0])              win = 0;
    else if (el[1] && el[2]) win = m_fav_dma ? 2 : 1;
    else if (el[1])          win = 1;
    else if (el[2])          win = 2;
    for (int r = 0; r < 3; r++) begin
      e_ack[r] = 1'b0;
      if (m_pend[r] && m_due[r] == m_cyc) begin
        e_ack[r] = 1'b1;
        if (!m_pwe[r]) e_rdata[r] = m_pdata[r];
        m_pend[r] = 1'b0;
      end
    end
    e_en = (win >= 0);
    if (win >= 0) begin
      case (win)
        0:       begin we = 1'b0;       a = bus.vid_addr; wd = e_wd;          end
        1:       begin we = bus.cpu_we; a = bus.cpu_addr; wd = bus.cpu_wdata; end
        default: begin we = bus.dma_we; a = bus.dma_addr; wd = bus.dma_wdata; end
      endcase
      e_we = we; e_addr = a; e_wd = wd;
      if (we) begin
        lw_valid = 1'b1; lw_addr = a; lw_old = ref_mem[a]; lw_oldv = ref_wr[a];
        ref_mem[a] = wd; ref_wr[a] = 1'b1;
      end
      m_pdata[win] = ref_rd(a);
      m_pwe[win]   = we;
      m_pend[win]  = 1'b1;
      m_due[win]   = m_cyc + 2;
      if (win == 1)      m_fav_dma = 1'b1;
      else if (win == 2) m_fav_dma = 1'b0;
    end
    m_cyc++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (lw_valid) begin  // write granted but never reached the RAM
        ref_mem[lw_addr] = lw_old;
        ref_wr[lw_addr]  = lw_oldv;
      end
      lw_valid = 1'b0;
      for (int r = 0; r < 3; r++) begin
        m_pend[r] = 1'b0; e_ack[r] = 1'b0; e_rdata[r] = 8'd0;
      end
      e_en = 1'b0; e_we = 1'b0; e_addr = 13'd0; e_wd = 8'd0; m_fav_dma = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("vid_ack",   32'(bus.vid_ack),   32'(e_ack[0]));
    chk("cpu_ack",   32'(bus.cpu_ack),   32'(e_ack[1]));
    chk("dma_ack",   32'(bus.dma_ack),   32'(e_ack[2]));
    chk("vid_rdata", 32'(bus.vid_rdata), 32'(e_rdata[0]));
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata[1]));
    chk("dma_rdata", 32'(bus.dma_rdata), 32'(e_rdata[2]));
    chk("mem_en",    32'(bus.mem_en),    32'(e_en));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
  endtask

  always @(posedge clk) begin
    #1;
    check_all();
  end

  // ---------------- stimulus ----------------
  bit cont_c = 1'b0, cont_d = 1'b0, rnd_on = 1'b0;
  int ack_c = 0, ack_d = 0;

  task automatic auto_drive();
    if (cont_c && (!bus.cpu_req || bus.cpu_ack)) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 13'($urandom_range(0, 63)); bus.cpu_wdata = 8'($urandom);
    end
    if (cont_d && (!bus.dma_req || bus.dma_ack)) begin
      bus.dma_req = 1'b1; bus.dma_we = 1'b1;
      bus.dma_addr = 13'($urandom_range(0, 63)); bus.dma_wdata = 8'($urandom);
    end
    if (rnd_on) begin
      if (!bus.vid_req || bus.vid_ack) begin
        bus.vid_req  = ($urandom_range(0, 2) != 0);
        bus.vid_addr = 13'($urandom_range(0, 40));
      end
      if (!bus.cpu_req || bus.cpu_ack) begin
        bus.cpu_req = ($urandom_range(0, 2) != 0); bus.cpu_we = 1'($urandom);
        bus.cpu_addr = 13'($urandom_range(0, 40)); bus.cpu_wdata = 8'($urandom);
      end
      if (!bus.dma_req || bus.dma_ack) begin
        bus.dma_req = ($urandom_range(0, 2) != 0); bus.dma_we = 1'($urandom);
        bus.dma_addr = ($urandom_range(0, 9) == 0) ? 13'h1FFF : 13'($urandom_range(0, 40));
        bus.dma_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    auto_drive();
  endtask

  task automatic drop_all();
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
  endtask

  // Mid-cycle reset: outputs must clear immediately; release with requests low.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_en",  32'(bus.mem_en),  32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_acks", 32'({bus.vid_ack, bus.cpu_ack, bus.dma_ack}), 32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    @(negedge clk);
    drop_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
      chk("idle_acks", 32'({bus.vid_ack, bus.cpu_ack, bus.dma_ack}), 32'd0);
    end
  endtask

  initial begin
    int bad_we;
    rst_n = 1'b0;
    bus.vid_req = 1'b0; bus.vid_addr = 13'd0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 13'd0; bus.cpu_wdata = 8'd0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 13'd0; bus.dma_wdata = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("init_mem_en", 32'(bus.mem_en), 32'd0);
    end

    // CPU read of 0x0123 returning 0x5A, acked two edges after its grant
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
    @(negedge clk);
    chk("t2_mem_en", 32'(bus.mem_en), 32'd1);
    chk("t2_mem_addr", 32'(bus.mem_addr), 32'h0123);
    chk("t2_ack_early", 32'(bus.cpu_ack), 32'd0);
    @(negedge clk);
    chk("t2_ack_e1", 32'(bus.cpu_ack), 32'd0);
    @(negedge clk);
    chk("t2_ack", 32'(bus.cpu_ack), 32'd1);
    chk("t2_rdata", 32'(bus.cpu_rdata), 32'h5A);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t2_ack_pulse", 32'(bus.cpu_ack), 32'd0);

    // Three simultaneous reads: grants V, C, D then acks in the same order
    do_reset();
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0020;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 13'h0030;
    @(negedge clk);
    chk("t3_g1", 32'(bus.mem_addr), 32'h0010);
    @(negedge clk);
    chk("t3_g2", 32'(bus.mem_addr), 32'h0020);
    @(negedge clk);
    chk("t3_g3", 32'(bus.mem_addr), 32'h0030);
    chk("t3_vack", 32'(bus.vid_ack), 32'd1);
    bus.vid_req = 1'b0;
    @(negedge clk);
    chk("t3_cack", 32'({bus.vid_ack, bus.cpu_ack, bus.dma_ack}), 32'b010);
    chk("t3_idle", 32'(bus.mem_en), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t3_dack", 32'({bus.vid_ack, bus.cpu_ack, bus.dma_ack}), 32'b001);
    bus.dma_req = 1'b0;

    // CPU and DMA writing back to back for 200 cycles
    cont_c = 1'b1; cont_d = 1'b1; bad_we = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.cpu_ack) ack_c++;
      if (bus.dma_ack) ack_d++;
      if (bus.mem_en && !bus.mem_we) bad_we++;
    end
    chk("t4_balance", 32'((ack_c - ack_d <= 1) && (ack_d - ack_c <= 1)), 32'd1);
    chk("t4_throughput", 32'(ack_c + ack_d >= 130), 32'd1);
    chk("t4_we", 32'(bad_we), 32'd0);

    // Video request at 0x1FFF overtakes a CPU that is about to be eligible
    cont_d = 1'b0; bus.dma_req = 1'b0;
    for (int i = 0; i < 12 && !bus.cpu_ack; i++) tick();
    chk("t5_cpu_ack_seen", 32'(bus.cpu_ack), 32'd1);
    bus.vid_req = 1'b1; bus.vid_addr = 13'h1FFF;
    tick();
    chk("t5_vgrant", 32'(bus.mem_addr), 32'h1FFF);
    chk("t5_vwe", 32'(bus.mem_we), 32'd0);
    tick();
    tick();
    chk("t5_vack", 32'(bus.vid_ack), 32'd1);
    bus.vid_req = 1'b0;
    cont_c = 1'b0; bus.cpu_req = 1'b0;
    repeat (4) tick();

    // Reset while a DMA access is in flight: no ack, clean regrant after release
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 13'h0456;
    @(negedge clk);
    chk("t6_grant", 32'(bus.mem_addr), 32'h0456);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    chk("t6_no_ack", 32'(bus.dma_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_regrant_en", 32'(bus.mem_en), 32'd1);
    chk("t6_regrant_addr", 32'(bus.mem_addr), 32'h0456);
    chk("t6_no_ack2", 32'(bus.dma_ack), 32'd0);
    @(negedge clk);
    chk("t6_no_ack3", 32'(bus.dma_ack), 32'd0);
    @(negedge clk);
    chk("t6_ack", 32'(bus.dma_ack), 32'd1);
    bus.dma_req = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized mixed traffic with a reset in the middle
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rnd_on = 1'b0;
        do_reset();
        rnd_on = 1'b1;
      end
      tick();
    end
    rnd_on = 1'b0;
    drop_all();
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
